state_reg_arbiter: RTL and testbench

Shares one WIDTH-bit state register among NREQ requesters via round-robin arbitration, with a one-cycle load acknowledge per requester. A FORCE control overrides the register with a constant and blocks all loads. When FORCE is released, the block passes through a one-cycle settle state before loads resume. The block sits in front of the state/data register path and sequences every write to it.

---
 rtl/state_reg_arbiter.sv | 138 +++++++++++++
 tb/tb_state_reg_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/state_reg_arbiter.sv
// Round-robin arbiter sequencing writes into a shared WIDTH-bit state register, with FORCE override.
// Optional build macro: STATE_ARB_FIXED_PRIO_EN (lowest eligible index always wins, no rotating pointer).
module state_reg_arbiter #(
  parameter int unsigned      NREQ        = 4,
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] FORCE_VALUE = '0
) (
  input  logic                  CLOCK,
  input  logic                  RST,
  input  logic                  FORCE,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DATA_IN,
  output logic [NREQ-1:0]       ACK,
  output logic [WIDTH-1:0]      STATE,
  output logic [2:0]            GNT_ID,
  output logic                  FORCED,
  output logic                  BUSY
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FORCED,
    S_SETTLE
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
`ifndef STATE_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  logic [WIDTH-1:0] data_arr [NREQ];
  logic [NREQ-1:0]  eligible;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = DATA_IN[g*WIDTH +: WIDTH];
  end

  // A requester acked this cycle is masked so it is not reloaded while it drops REQ.
  always_comb begin : arbitrate
    eligible  = REQ & ~ack_q;
    win_valid = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef STATE_ARB_FIXED_PRIO_EN
      cand_idx = IDX_W'(i);
`else
      cand_idx = IDX_W'((32'(ptr_q) + i) % NREQ);
`endif
      if (!win_valid && eligible[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin : next_state
    fsm_d    = fsm_q;
    state_d  = state_q;
    ack_d    = '0;
    gnt_id_d = gnt_id_q;
`ifndef STATE_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    unique case (fsm_q)
      S_IDLE, S_LOAD: begin
        if (FORCE) begin
          fsm_d   = S_FORCED;
          state_d = FORCE_VALUE;
        end else if (win_valid) begin
          fsm_d          = S_LOAD;
          state_d        = data_arr[win_idx];
          ack_d[win_idx] = 1'b1;
          gnt_id_d       = 3'(win_idx);
`ifndef STATE_ARB_FIXED_PRIO_EN
          ptr_d          = IDX_W'((32'(win_idx) + 1) % NREQ);
`endif
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_FORCED: begin
        state_d = FORCE_VALUE;
        fsm_d   = FORCE ? S_FORCED : S_SETTLE;
      end
      S_SETTLE: begin
        if (FORCE) begin
          fsm_d   = S_FORCED;
          state_d = FORCE_VALUE;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    // BUSY is registered so it reads 0 throughout reset regardless of REQ.
    busy_d = (|eligible) || (fsm_d == S_FORCED) || (fsm_d == S_SETTLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      fsm_q    <= S_IDLE;
      state_q  <= '0;
      ack_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
`ifndef STATE_ARB_FIXED_PRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      ack_q    <= ack_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
`ifndef STATE_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign ACK    = ack_q;
  assign STATE  = state_q;
  assign GNT_ID = gnt_id_q;
  assign BUSY   = busy_q;
  assign FORCED = (fsm_q == S_FORCED) || (fsm_q == S_SETTLE);

endmodule

// File: tb/tb_state_reg_arbiter.sv
// Scoreboard bench for state_reg_arbiter: reference model pushes expected outputs per cycle.
module tb_state_reg_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam logic [3:0]  FV    = 4'h9;

  logic        CLOCK = 1'b0;
  logic        RST   = 1'b1;
  logic        FORCE = 1'b0;
  logic [3:0]  REQ   = '0;
  logic [15:0] DATA_IN = '0;
  logic [3:0]  ACK;
  logic [3:0]  STATE;
  logic [2:0]  GNT_ID;
  logic        FORCED;
  logic        BUSY;

  state_reg_arbiter #(
    .NREQ       (NREQ),
    .WIDTH      (WIDTH),
    .FORCE_VALUE(FV)
  ) dut (
    .CLOCK  (CLOCK),
    .RST    (RST),
    .FORCE  (FORCE),
    .REQ    (REQ),
    .DATA_IN(DATA_IN),
    .ACK    (ACK),
    .STATE  (STATE),
    .GNT_ID (GNT_ID),
    .FORCED (FORCED),
    .BUSY   (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] state;
    logic [2:0] gnt;
    logic       forced;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: fsm 0=IDLE 1=LOAD 2=FORCED 3=SETTLE
  int         m_fsm = 0;
  int         m_ptr = 0;
  logic [3:0] m_state = '0;
  logic [3:0] m_ack = '0;
  logic [2:0] m_gnt = '0;
  logic       m_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] elig;
    logic [3:0] nack;
    int         win;
    int         idx;
    exp_t       e;
    if (RST) begin
      m_fsm = 0; m_ptr = 0; m_state = '0; m_ack = '0; m_gnt = '0; m_busy = 1'b0;
    end else begin
      elig = REQ & ~m_ack;
      nack = '0;
      win  = -1;
      for (int k = 0; k < 4; k++) begin
`ifdef STATE_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % 4;
`endif
        if (win < 0 && elig[idx]) win = idx;
      end
      case (m_fsm)
        0, 1: begin
          if (FORCE) begin
            m_fsm = 2; m_state = FV;
          end else if (win >= 0) begin
            m_fsm = 1;
            m_state = DATA_IN[win*4 +: 4];
            nack[win] = 1'b1;
            m_gnt = win[2:0];
            m_ptr = (win + 1) % 4;
          end else begin
            m_fsm = 0;
          end
        end
        2: begin
          m_state = FV;
          m_fsm = FORCE ? 2 : 3;
        end
        default: begin
          if (FORCE) begin
            m_fsm = 2; m_state = FV;
          end else begin
            m_fsm = 0;
          end
        end
      endcase
      m_ack  = nack;
      m_busy = (elig != 0) || (m_fsm >= 2);
    end
    e.ack = m_ack; e.state = m_state; e.gnt = m_gnt;
    e.forced = (m_fsm >= 2); e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge CLOCK);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("sb_ack", ACK, e.ack);
      check("sb_state", STATE, e.state);
      check("sb_gnt", GNT_ID, e.gnt);
      check("sb_forced", FORCED, e.forced);
      check("sb_busy", BUSY, e.busy);
    end
  endtask

`ifdef STATE_ARB_FIXED_PRIO_EN
  logic [3:0] rr_ack [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
  logic [3:0] rr_st  [5] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
`else
  logic [3:0] rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_st  [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
`endif

  initial begin
    // reset with all requests asserted
    RST = 1'b1; REQ = 4'hF; DATA_IN = 16'h4321;
    cyc(); cyc();
    check("rst_ack", ACK, 4'b0000);
    check("rst_state", STATE, 4'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_forced", FORCED, 1'b0);

    // rotating service with all four held
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr_ack", ACK, rr_ack[i]);
      check("rr_state", STATE, rr_st[i]);
    end
    REQ = '0;
    cyc(); cyc();

    // single requester, one-cycle window
    REQ = 4'b0100; DATA_IN = 16'h4A21;
    cyc();
    check("single_ack", ACK, 4'b0100);
    check("single_state", STATE, 4'hA);
    check("single_gnt", GNT_ID, 3'd2);
    REQ = '0;
    cyc();
    check("single_noack", ACK, 4'b0000);
    cyc();

    // single requester held: alternate-cycle loads
    REQ = 4'b0001;
    repeat (4) cyc();
    REQ = '0;
    cyc();

    // force beats a same-cycle request
    REQ = 4'b0010; FORCE = 1'b1;
    cyc();
    check("frc_ack", ACK, 4'b0000);
    check("frc_state", STATE, FV);
    check("frc_forced", FORCED, 1'b1);
    cyc();
    FORCE = 1'b0;
    cyc();
    check("settle_forced", FORCED, 1'b1);
    check("settle_ack", ACK, 4'b0000);
    check("settle_state", STATE, FV);
    cyc();
    check("post_settle_ack", ACK, 4'b0000);
    cyc();
    check("release_ack", ACK, 4'b0010);
    check("release_state", STATE, 4'h2);
    REQ = '0;
    cyc();

    // reset while forced
    FORCE = 1'b1;
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    check("rstf_forced", FORCED, 1'b0);
    RST = 1'b0;
    cyc();
    check("rstf_reforced", FORCED, 1'b1);
    FORCE = 1'b0;
    cyc(); cyc();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST     = ($urandom_range(0, 59) == 0);
      FORCE   = ($urandom_range(0, 7) == 0) ? ~FORCE : FORCE;
      REQ     = 4'($urandom);
      DATA_IN = 16'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
